// File: rtl/brick_matrix_ctrl.sv
// Live brick map for the breakout playfield: loads a level layout from ROM row by row,
// then applies at most one missile hit per missile per frame at the start of each frame.
module brick_matrix_ctrl #(
   parameter int ROWS          = 14,
   parameter int COLS          = 17,
   parameter int HITS_TO_BREAK = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         startOfFrame,
   input  logic                         loadLevel,
   output logic [3:0]                   levelRomAddr,
   input  logic [0:COLS-1]              levelRomData,
   input  logic                         collisionMissle1Brick,
   input  logic                         collisionMissle2Brick,
   input  logic [4:0]                   brickCollisionX,
   input  logic [3:0]                   brickCollisionY,
   output logic [0:ROWS-1][0:COLS-1]    brickMatrix,
   output logic [7:0]                   bricksRemaining,
   output logic                         brickDestroyed,
   output logic                         loadBusy
);

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LOAD   = 3'd1;
   localparam logic [2:0] RUN    = 3'd2;
   localparam logic [2:0] APPLY1 = 3'd3;
   localparam logic [2:0] APPLY2 = 3'd4;

   localparam logic [1:0] HIT_INIT  = 2'(HITS_TO_BREAK);
   localparam logic [3:0] LAST_ROW  = 4'(ROWS - 1);
   localparam logic [3:0] LOAD_LAST = 4'(ROWS);
   localparam logic [4:0] COLS_W    = 5'(COLS);
   localparam logic [3:0] ROWS_W    = 4'(ROWS);

   logic [2:0] state;
   logic [3:0] loadCnt;
   logic [3:0] loadRow;
   logic [4:0] loadRowCount;
   logic [1:0] health [ROWS][COLS];

   logic       pendValid1, pendValid2;
   logic [4:0] pendX1, pendX2;
   logic [3:0] pendY1, pendY2;
   logic       applyValid1, applyValid2;
   logic [4:0] applyX1, applyX2;
   logic [3:0] applyY1, applyY2;

   logic       acceptHits;
   logic       frameLatch;
   logic       curValid;
   logic [4:0] curX;
   logic [3:0] curY;
   logic       inRange;
   logic [4:0] safeX;
   logic [3:0] safeY;
   logic [1:0] curHealth;
   logic       hitOk;
   logic       killsBrick;

   assign loadBusy   = (state == LOAD);
   assign acceptHits = (state == RUN) || (state == APPLY1) || (state == APPLY2);
   assign frameLatch = (state == RUN) && startOfFrame;
   assign loadRow    = loadCnt - 4'd1;

   always_comb begin
      loadRowCount = '0;
      for (int c = 0; c < COLS; c++) begin
         loadRowCount = loadRowCount + {4'd0, levelRomData[c]};
      end
   end

   // Select which latched hit the current apply state works on; out-of-range
   // coordinates are folded to cell 0 so the array reads stay in bounds.
   always_comb begin
      curValid = 1'b0;
      curX     = '0;
      curY     = '0;
      if (state == APPLY1) begin
         curValid = applyValid1;
         curX     = applyX1;
         curY     = applyY1;
      end else if (state == APPLY2) begin
         curValid = applyValid2;
         curX     = applyX2;
         curY     = applyY2;
      end
   end

   assign inRange    = (curX < COLS_W) && (curY < ROWS_W);
   assign safeX      = inRange ? curX : 5'd0;
   assign safeY      = inRange ? curY : 4'd0;
   assign curHealth  = health[safeY][safeX];
   assign hitOk      = curValid && inRange && brickMatrix[safeY][safeX];
   assign killsBrick = hitOk && (curHealth <= 2'd1);

   // Sequencing: LOAD walks the ROM address and lingers one extra cycle so the
   // last row's data, which arrives a cycle late, can still be written.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         levelRomAddr <= '0;
         loadCnt      <= '0;
      end else if (loadLevel) begin
         state        <= LOAD;
         levelRomAddr <= '0;
         loadCnt      <= '0;
      end else begin
         case (state)
            IDLE: ;
            LOAD: begin
               loadCnt <= loadCnt + 4'd1;
               if (levelRomAddr < LAST_ROW) begin
                  levelRomAddr <= levelRomAddr + 4'd1;
               end
               if (loadCnt == LOAD_LAST) begin
                  state <= RUN;
               end
            end
            RUN: begin
               if (startOfFrame) begin
                  state <= APPLY1;
               end
            end
            APPLY1:  state <= APPLY2;
            APPLY2:  state <= RUN;
            default: state <= IDLE;
         endcase
      end
   end

   // Each missile keeps only its first hit of the frame; at frame start the
   // pending hit moves to the apply slot and a same-cycle collision starts the next frame.
   always_ff @(posedge clk) begin
      if (reset || loadLevel) begin
         pendValid1  <= 1'b0;
         pendX1      <= '0;
         pendY1      <= '0;
         pendValid2  <= 1'b0;
         pendX2      <= '0;
         pendY2      <= '0;
         applyValid1 <= 1'b0;
         applyX1     <= '0;
         applyY1     <= '0;
         applyValid2 <= 1'b0;
         applyX2     <= '0;
         applyY2     <= '0;
      end else begin
         if (frameLatch) begin
            applyValid1 <= pendValid1;
            applyX1     <= pendX1;
            applyY1     <= pendY1;
            applyValid2 <= pendValid2;
            applyX2     <= pendX2;
            applyY2     <= pendY2;
         end
         if (acceptHits && collisionMissle1Brick && (!pendValid1 || frameLatch)) begin
            pendValid1 <= 1'b1;
            pendX1     <= brickCollisionX;
            pendY1     <= brickCollisionY;
         end else if (frameLatch) begin
            pendValid1 <= 1'b0;
         end
         if (acceptHits && collisionMissle2Brick && (!pendValid2 || frameLatch)) begin
            pendValid2 <= 1'b1;
            pendX2     <= brickCollisionX;
            pendY2     <= brickCollisionY;
         end else if (frameLatch) begin
            pendValid2 <= 1'b0;
         end
      end
   end

   // Map, health and remaining count: rows are written during LOAD, single
   // cells are damaged during the apply states.
   always_ff @(posedge clk) begin
      if (reset) begin
         brickMatrix     <= '0;
         bricksRemaining <= '0;
         brickDestroyed  <= 1'b0;
         for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
               health[r][c] <= 2'd0;
            end
         end
      end else begin
         brickDestroyed <= 1'b0;
         if (loadLevel) begin
            bricksRemaining <= '0;
         end else if (state == LOAD) begin
            if (loadCnt != 4'd0) begin
               brickMatrix[loadRow] <= levelRomData;
               bricksRemaining      <= bricksRemaining + {3'd0, loadRowCount};
               for (int c = 0; c < COLS; c++) begin
                  health[loadRow][c] <= levelRomData[c] ? HIT_INIT : 2'd0;
               end
            end
         end else if (hitOk) begin
            health[safeY][safeX] <= killsBrick ? 2'd0 : (curHealth - 2'd1);
            if (killsBrick) begin
               brickMatrix[safeY][safeX] <= 1'b0;
               brickDestroyed            <= 1'b1;
               if (bricksRemaining != 8'd0) begin
                  bricksRemaining <= bricksRemaining - 8'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_brick_matrix_ctrl.sv
// Directed testbench for brick_matrix_ctrl: level loading, per-frame damage,
// invalid hits, load interruption and reset during an apply state.
module tb_brick_matrix_ctrl;

   localparam int ROWS = 14;
   localparam int COLS = 17;

   logic                      clk = 1'b0;
   logic                      reset;
   logic                      startOfFrame;
   logic                      loadLevel;
   logic [3:0]                levelRomAddr;
   logic [0:COLS-1]           levelRomData;
   logic                      collisionMissle1Brick;
   logic                      collisionMissle2Brick;
   logic [4:0]                brickCollisionX;
   logic [3:0]                brickCollisionY;
   logic [0:ROWS-1][0:COLS-1] brickMatrix;
   logic [7:0]                bricksRemaining;
   logic                      brickDestroyed;
   logic                      loadBusy;

   logic [0:COLS-1]           romMem [ROWS];
   logic [0:ROWS-1][0:COLS-1] expMatrix;
   int                        checks = 0;
   int                        errors = 0;

   brick_matrix_ctrl dut (
      .clk                   (clk),
      .reset                 (reset),
      .startOfFrame          (startOfFrame),
      .loadLevel             (loadLevel),
      .levelRomAddr          (levelRomAddr),
      .levelRomData          (levelRomData),
      .collisionMissle1Brick (collisionMissle1Brick),
      .collisionMissle2Brick (collisionMissle2Brick),
      .brickCollisionX       (brickCollisionX),
      .brickCollisionY       (brickCollisionY),
      .brickMatrix           (brickMatrix),
      .bricksRemaining       (bricksRemaining),
      .brickDestroyed        (brickDestroyed),
      .loadBusy              (loadBusy)
   );

   always #5 clk = ~clk;

   // Synchronous level ROM: data follows the address by one clock.
   always @(posedge clk) begin
      levelRomData <= romMem[levelRomAddr];
   end

   task automatic applyStimulus(input logic m1, input logic m2, input logic [4:0] x,
                                input logic [3:0] y, input int cycles);
      collisionMissle1Brick = m1;
      collisionMissle2Brick = m2;
      brickCollisionX       = x;
      brickCollisionY       = y;
      repeat (cycles) @(negedge clk);
      collisionMissle1Brick = 1'b0;
      collisionMissle2Brick = 1'b0;
      brickCollisionX       = '0;
      brickCollisionY       = '0;
   endtask

   task automatic runFrame(output int pulses);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      pulses = 0;
      repeat (6) begin
         if (brickDestroyed === 1'b1) pulses++;
         @(negedge clk);
      end
   endtask

   task automatic runLoad(output int busyCycles);
      int expAddr;
      loadLevel = 1'b1;
      @(negedge clk);
      loadLevel = 1'b0;
      busyCycles = 0;
      for (int k = 0; k < 40 && loadBusy === 1'b1; k++) begin
         expAddr = (k < 13) ? k : 13;
         checks++;
         if (levelRomAddr !== 4'(expAddr)) begin
            errors++;
            $display("[TB] FAIL load_addr cycle %0d: got %0d expected %0d", k, levelRomAddr, expAddr);
         end
         busyCycles++;
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (brickMatrix !== '0) begin
         errors++;
         $display("[TB] FAIL reset_matrix: got %h expected 0", brickMatrix);
      end
      checks++;
      if (bricksRemaining !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_remaining: got %0d expected 0", bricksRemaining);
      end
      checks++;
      if (loadBusy !== 1'b0 || brickDestroyed !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: busy %b destroyed %b expected 0 0", loadBusy, brickDestroyed);
      end
      checks++;
      if (levelRomAddr !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_addr: got %0d expected 0", levelRomAddr);
      end
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_load_all_ones;
      int busy;
      for (int r = 0; r < ROWS; r++) romMem[r] = '1;
      runLoad(busy);
      expMatrix = '1;
      checks++;
      if (busy !== 15) begin
         errors++;
         $display("[TB] FAIL load_busy_len: got %0d expected 15", busy);
      end
      checks++;
      if (brickMatrix !== expMatrix) begin
         errors++;
         $display("[TB] FAIL load_matrix: got %h expected %h", brickMatrix, expMatrix);
      end
      checks++;
      if (bricksRemaining !== 8'd238) begin
         errors++;
         $display("[TB] FAIL load_remaining: got %0d expected 238", bricksRemaining);
      end
   endtask

   task automatic test_two_hit;
      int p;
      applyStimulus(1'b1, 1'b0, 5'd3, 4'd5, 10);
      runFrame(p);
      checks++;
      if (p !== 0 || brickMatrix !== expMatrix || bricksRemaining !== 8'd238) begin
         errors++;
         $display("[TB] FAIL two_hit_first: pulses %0d remaining %0d cell %b expected 0 238 1",
                  p, bricksRemaining, brickMatrix[5][3]);
      end
      applyStimulus(1'b1, 1'b0, 5'd3, 4'd5, 10);
      runFrame(p);
      expMatrix[5][3] = 1'b0;
      checks++;
      if (p !== 1) begin
         errors++;
         $display("[TB] FAIL two_hit_pulse: got %0d expected 1", p);
      end
      checks++;
      if (brickMatrix !== expMatrix) begin
         errors++;
         $display("[TB] FAIL two_hit_matrix: got %h expected %h", brickMatrix, expMatrix);
      end
      checks++;
      if (bricksRemaining !== 8'd237) begin
         errors++;
         $display("[TB] FAIL two_hit_remaining: got %0d expected 237", bricksRemaining);
      end
   endtask

   task automatic test_same_brick;
      int p;
      applyStimulus(1'b1, 1'b1, 5'd2, 4'd2, 1);
      runFrame(p);
      expMatrix[2][2] = 1'b0;
      checks++;
      if (p !== 1) begin
         errors++;
         $display("[TB] FAIL same_brick_pulse: got %0d expected 1", p);
      end
      checks++;
      if (brickMatrix !== expMatrix || bricksRemaining !== 8'd236) begin
         errors++;
         $display("[TB] FAIL same_brick_state: cell %b remaining %0d expected 0 236",
                  brickMatrix[2][2], bricksRemaining);
      end
   endtask

   task automatic test_invalid_hits;
      int busy;
      int p;
      for (int r = 0; r < ROWS; r++) romMem[r] = '1;
      romMem[3][0] = 1'b0;
      runLoad(busy);
      expMatrix = '1;
      expMatrix[3][0] = 1'b0;
      checks++;
      if (busy !== 15 || bricksRemaining !== 8'd237 || brickMatrix !== expMatrix) begin
         errors++;
         $display("[TB] FAIL invalid_reload: busy %0d remaining %0d expected 15 237", busy, bricksRemaining);
      end
      applyStimulus(1'b1, 1'b0, 5'd20, 4'd3, 1);
      runFrame(p);
      checks++;
      if (p !== 0 || brickMatrix !== expMatrix || bricksRemaining !== 8'd237) begin
         errors++;
         $display("[TB] FAIL invalid_x: pulses %0d remaining %0d expected 0 237", p, bricksRemaining);
      end
      applyStimulus(1'b0, 1'b1, 5'd0, 4'd3, 1);
      runFrame(p);
      checks++;
      if (p !== 0 || brickMatrix !== expMatrix || bricksRemaining !== 8'd237) begin
         errors++;
         $display("[TB] FAIL invalid_empty: pulses %0d remaining %0d expected 0 237", p, bricksRemaining);
      end
   endtask

   task automatic test_load_interrupt;
      int busy;
      for (int r = 0; r < ROWS; r++) romMem[r] = '1;
      loadLevel = 1'b1;
      @(negedge clk);
      loadLevel = 1'b0;
      repeat (7) @(negedge clk);
      checks++;
      if (levelRomAddr !== 4'd7 || loadBusy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL interrupt_mid: addr %0d busy %b expected 7 1", levelRomAddr, loadBusy);
      end
      runLoad(busy);
      expMatrix = '1;
      checks++;
      if (busy !== 15) begin
         errors++;
         $display("[TB] FAIL interrupt_busy_len: got %0d expected 15", busy);
      end
      checks++;
      if (bricksRemaining !== 8'd238 || brickMatrix !== expMatrix) begin
         errors++;
         $display("[TB] FAIL interrupt_result: remaining %0d expected 238", bricksRemaining);
      end
   endtask

   task automatic test_pending_discard;
      int busy;
      int p1;
      int p2;
      applyStimulus(1'b1, 1'b0, 5'd5, 4'd5, 1);
      runLoad(busy);
      runFrame(p1);
      applyStimulus(1'b1, 1'b0, 5'd5, 4'd5, 1);
      runFrame(p2);
      checks++;
      if (p1 + p2 !== 0 || brickMatrix !== expMatrix) begin
         errors++;
         $display("[TB] FAIL pending_discard: pulses %0d cell %b expected 0 1", p1 + p2, brickMatrix[5][5]);
      end
      checks++;
      if (bricksRemaining !== 8'd238) begin
         errors++;
         $display("[TB] FAIL pending_remaining: got %0d expected 238", bricksRemaining);
      end
   endtask

   task automatic test_reset_mid_apply;
      int pulses;
      applyStimulus(1'b1, 1'b0, 5'd5, 4'd5, 1);
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if (brickMatrix !== '0 || bricksRemaining !== 8'd0) begin
         errors++;
         $display("[TB] FAIL reset_apply_state: remaining %0d expected 0", bricksRemaining);
      end
      checks++;
      if (brickDestroyed !== 1'b0 || loadBusy !== 1'b0 || levelRomAddr !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_apply_flags: destroyed %b busy %b addr %0d expected 0 0 0",
                  brickDestroyed, loadBusy, levelRomAddr);
      end
      reset = 1'b0;
      pulses = 0;
      startOfFrame = 1'b1;
      @(negedge clk);
      startOfFrame = 1'b0;
      repeat (5) begin
         if (brickDestroyed === 1'b1) pulses++;
         @(negedge clk);
      end
      checks++;
      if (pulses !== 0 || loadBusy !== 1'b0 || brickMatrix !== '0) begin
         errors++;
         $display("[TB] FAIL reset_apply_after: pulses %0d busy %b expected 0 0", pulses, loadBusy);
      end
   endtask

   initial begin
      reset                 = 1'b1;
      startOfFrame          = 1'b0;
      loadLevel             = 1'b0;
      collisionMissle1Brick = 1'b0;
      collisionMissle2Brick = 1'b0;
      brickCollisionX       = '0;
      brickCollisionY       = '0;
      for (int r = 0; r < ROWS; r++) romMem[r] = '1;
      test_reset();
      test_load_all_ones();
      test_two_hit();
      test_same_brick();
      test_invalid_hits();
      test_load_interrupt();
      test_pending_discard();
      test_reset_mid_apply();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
